unidade_busca: RTL and testbench

// - Instruction-fetch stage. It sits directly upstream of the decode/register-file stage of Processador.
// - Owns the PC and issues one-cycle-latency reads to the instruction memory.
// - Buffers the returned words in a small queue and presents them downstream with a valid/ready handshake.
// - Takes branch redirects from the ALU and raises a sticky halt when the end-of-program word reaches the queue head.

---
 rtl/unidade_busca_pkg.sv | 11 +
 rtl/unidade_busca_if.sv | 28 ++
 rtl/unidade_busca_fila.sv | 85 ++++++++
 rtl/unidade_busca.sv | 102 ++++++++++
 tb/tb_unidade_busca.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/unidade_busca_pkg.sv
// Processor-wide constants and types shared by the fetch, decode and ALU stages.
package pkg_processador;

  localparam int          LARGURA_INST = 32;
  localparam logic [31:0] INST_FIM     = 32'hFFFF_FFFF;
  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          PC_INCR      = 4;

  typedef logic [LARGURA_INST-1:0] inst_t;

endpackage

// File: rtl/unidade_busca_if.sv
// Fetch-stage bus: instruction-memory read port, ALU redirect input and downstream handshake.
interface unidade_busca_if #(
  parameter int LARGURA_PC = 32
);
  import pkg_processador::*;

  logic                  mem_req;
  logic [LARGURA_PC-1:0] mem_ender;
  inst_t                 mem_dado;
  logic                  desvio_valido;
  logic [LARGURA_PC-1:0] desvio_alvo;
  logic                  inst_valida;
  logic                  inst_pronto;
  inst_t                 inst_saida;
  logic [LARGURA_PC-1:0] pc_saida;
  logic                  parado;

  modport master (
    output mem_req, mem_ender, inst_valida, inst_saida, pc_saida, parado,
    input  mem_dado, desvio_valido, desvio_alvo, inst_pronto
  );

  modport slave (
    input  mem_req, mem_ender, inst_valida, inst_saida, pc_saida, parado,
    output mem_dado, desvio_valido, desvio_alvo, inst_pronto
  );

endinterface

// File: rtl/unidade_busca_fila.sv
// Small FIFO of {pc, instruction} pairs with flush; the head is read combinationally
// so a pushed word is visible downstream on the very next cycle.
module fila_instrucoes
  import pkg_processador::*;
#(
  parameter  int LARGURA_PC = 32,
  parameter  int PROF       = 2,
  localparam int PTR_W      = (PROF > 1) ? $clog2(PROF) : 1,
  localparam int OCC_W      = $clog2(PROF + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [LARGURA_PC-1:0] pc_in,
  input  inst_t                 inst_in,
  output logic [LARGURA_PC-1:0] pc_cabeca,
  output inst_t                 inst_cabeca,
  output logic [OCC_W-1:0]      ocupacao
);

  logic [LARGURA_PC-1:0] pc_mem_q   [PROF];
  logic [LARGURA_PC-1:0] pc_mem_d   [PROF];
  inst_t                 inst_mem_q [PROF];
  inst_t                 inst_mem_d [PROF];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;

  function automatic logic [PTR_W-1:0] avanca(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(PROF - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    // Flush wins over a simultaneous push/pop: the caller is discarding everything.
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = pc_in;
        inst_mem_d[wr_ptr_q] = inst_in;
        wr_ptr_d             = avanca(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = avanca(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PROF; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
    end
  end

  assign pc_cabeca   = pc_mem_q[rd_ptr_q];
  assign inst_cabeca = inst_mem_q[rd_ptr_q];
  assign ocupacao    = occ_q;

endmodule

// File: rtl/unidade_busca.sv
// Instruction-fetch stage: owns the PC, issues one-cycle-latency memory reads, queues
// the returned words, handles ALU redirects and halts on the end-of-program word.
module unidade_busca
  import pkg_processador::inst_t, pkg_processador::PC_INCR;
#(
  parameter int                    LARGURA_PC = 32,
  parameter logic [LARGURA_PC-1:0] RESET_PC   = LARGURA_PC'(pkg_processador::RESET_PC),
  parameter int                    PROF_FILA  = 2,
  parameter inst_t                 INST_FIM   = pkg_processador::INST_FIM
) (
  input  logic            clock,
  input  logic            reset,
  unidade_busca_if.master bus
);

  localparam int OCC_W = $clog2(PROF_FILA + 1);
  localparam int CW    = OCC_W + 1;

  logic [LARGURA_PC-1:0] pc_q, pc_d;
  logic [LARGURA_PC-1:0] pc_voo_q, pc_voo_d;
  logic                  inflight_q, inflight_d;
  logic                  fim_visto_q, fim_visto_d;
  logic                  parado_q, parado_d;

  logic [OCC_W-1:0]      ocupacao;
  logic [LARGURA_PC-1:0] pc_cabeca;
  inst_t                 inst_cabeca;
  logic [CW-1:0]         carga;
  logic                  tem_dado, parado_w, valida_w;
  logic                  pop, push, desvio_ef, fim_chegando, emite;

  fila_instrucoes #(
    .LARGURA_PC(LARGURA_PC),
    .PROF      (PROF_FILA)
  ) u_fila (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (desvio_ef),
    .pc_in      (pc_voo_q),
    .inst_in    (bus.mem_dado),
    .pc_cabeca  (pc_cabeca),
    .inst_cabeca(inst_cabeca),
    .ocupacao   (ocupacao)
  );

  always_comb begin
    tem_dado     = (ocupacao != '0);
    // The end marker halts the moment it surfaces; it is never handed downstream.
    parado_w     = parado_q || (tem_dado && (inst_cabeca == INST_FIM));
    valida_w     = tem_dado && !parado_w;
    pop          = valida_w && bus.inst_pronto;
    desvio_ef    = bus.desvio_valido && !parado_w;
    // A redirect kills the response arriving this cycle; nothing can be in flight after it.
    push         = inflight_q && !desvio_ef;
    fim_chegando = push && (bus.mem_dado == INST_FIM);
    carga        = CW'(ocupacao) + CW'(inflight_q) - CW'(pop);
    emite        = !parado_w && !bus.desvio_valido && !fim_visto_q && !fim_chegando
                   && (carga < CW'(PROF_FILA));
  end

  always_comb begin
    pc_d        = pc_q;
    pc_voo_d    = pc_voo_q;
    inflight_d  = emite;
    fim_visto_d = fim_visto_q || fim_chegando;
    parado_d    = parado_w;
    if (desvio_ef) begin
      pc_d        = {bus.desvio_alvo[LARGURA_PC-1:2], 2'b00};
      fim_visto_d = 1'b0;
    end else if (emite) begin
      pc_d     = pc_q + LARGURA_PC'(PC_INCR);
      pc_voo_d = pc_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      pc_voo_q    <= '0;
      inflight_q  <= 1'b0;
      fim_visto_q <= 1'b0;
      parado_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pc_voo_q    <= pc_voo_d;
      inflight_q  <= inflight_d;
      fim_visto_q <= fim_visto_d;
      parado_q    <= parado_d;
    end
  end

  // Outputs are forced low while reset is held so nothing leaks out before release.
  assign bus.mem_req     = reset && emite;
  assign bus.mem_ender   = reset ? pc_q : '0;
  assign bus.inst_valida = reset && valida_w;
  assign bus.inst_saida  = (reset && valida_w) ? inst_cabeca : '0;
  assign bus.pc_saida    = (reset && valida_w) ? pc_cabeca : '0;
  assign bus.parado      = reset && parado_w;

endmodule

// File: tb/tb_unidade_busca.sv
// Directed and random stimulus for the fetch stage, checked against a program-order
// reference: accepted instructions and memory requests must follow the fetch stream.
module tb_unidade_busca;

  localparam logic [31:0] FIM = 32'hFFFF_FFFF;

  logic clock = 1'b0;
  logic reset = 1'b0;

  unidade_busca_if #(.LARGURA_PC(32)) bus_a ();
  unidade_busca_if #(.LARGURA_PC(32)) bus_b ();

  unidade_busca #(
    .LARGURA_PC(32), .RESET_PC(32'h0000_0000), .PROF_FILA(2), .INST_FIM(FIM)
  ) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a)
  );

  unidade_busca #(
    .LARGURA_PC(32), .RESET_PC(32'hFFFF_FFF8), .PROF_FILA(2), .INST_FIM(FIM)
  ) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  bit          modo_const = 1'b1;
  bit          fim_on     = 1'b0;
  logic [31:0] fim_addr   = 32'h10;
  logic [15:0] salt       = 16'h0A5C;

  logic [31:0] exp_pc, exp_req_pc;
  bit          parado_m, req_bloq, houve_desvio;
  int          fim_req_ciclo, ciclo, n_req, n_acc;
  logic [31:0] reqs_b[$];

  logic        s_req, s_valida, s_parado;
  logic [31:0] s_ender, s_inst, s_pc;

  function automatic logic [31:0] palavra(input logic [31:0] a);
    if (fim_on && a == fim_addr) return FIM;
    if (modo_const) return 32'h0000_0013;
    return {salt, a[15:0]};
  endfunction

  // Instruction memory: answers exactly one cycle after the request, junk otherwise.
  always @(posedge clock) begin
    bus_a.mem_dado <= bus_a.mem_req ? palavra(bus_a.mem_ender) : $urandom;
    bus_b.mem_dado <= 32'h0000_0013;
  end

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    assert (obs === esp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  task automatic passo(input logic pronto, input logic desvio, input logic [31:0] alvo);
    bit parado_exp;
    bit ef;
    bus_a.inst_pronto   = pronto;
    bus_a.desvio_valido = desvio;
    bus_a.desvio_alvo   = alvo;
    @(negedge clock);
    s_req    = bus_a.mem_req;
    s_ender  = bus_a.mem_ender;
    s_valida = bus_a.inst_valida;
    s_inst   = bus_a.inst_saida;
    s_pc     = bus_a.pc_saida;
    s_parado = bus_a.parado;
    if (bus_b.mem_req && reqs_b.size() < 3) reqs_b.push_back(bus_b.mem_ender);

    parado_exp = parado_m || (palavra(exp_pc) == FIM && fim_req_ciclo >= 0 &&
                              ciclo >= fim_req_ciclo + 2);
    verifica("parado", s_parado, parado_exp);
    if (palavra(exp_pc) == FIM) verifica("valida_fim", s_valida, 0);
    if (s_valida) begin
      verifica("pc_saida", s_pc, exp_pc);
      verifica("inst_saida", s_inst, palavra(exp_pc));
    end else begin
      verifica("pc_zero", s_pc, 0);
      verifica("inst_zero", s_inst, 0);
    end
    ef = desvio && !parado_exp;
    if (ef) verifica("req_no_desvio", s_req, 0);
    if (s_req) begin
      verifica("mem_ender", s_ender, exp_req_pc);
      verifica("req_apos_fim", req_bloq, 0);
      if (palavra(exp_req_pc) == FIM) begin
        req_bloq      = 1'b1;
        fim_req_ciclo = ciclo;
      end
      exp_req_pc = exp_req_pc + 32'd4;
      n_req++;
    end
    if (s_valida && pronto) begin
      exp_pc = exp_pc + 32'd4;
      n_acc++;
    end
    if (!houve_desvio) verifica("limite_ocup", (n_req - n_acc) <= 2, 1);
    if (ef) begin
      exp_pc        = alvo & ~32'h3;
      exp_req_pc    = alvo & ~32'h3;
      req_bloq      = 1'b0;
      fim_req_ciclo = -1;
      houve_desvio  = 1'b1;
    end
    parado_m = parado_exp;
    ciclo++;
    @(posedge clock);
    #1;
  endtask

  task automatic aplica_reset();
    bus_a.inst_pronto   = 1'b0;
    bus_a.desvio_valido = 1'b0;
    bus_a.desvio_alvo   = '0;
    reset = 1'b0;
    #1;
    verifica("rst_req", bus_a.mem_req, 0);
    verifica("rst_ender", bus_a.mem_ender, 0);
    verifica("rst_valida", bus_a.inst_valida, 0);
    verifica("rst_inst", bus_a.inst_saida, 0);
    verifica("rst_pc", bus_a.pc_saida, 0);
    verifica("rst_parado", bus_a.parado, 0);
    verifica("rst_ender_b", bus_b.mem_ender, 0);
    verifica("rst_req_b", bus_b.mem_req, 0);
    repeat (2) @(posedge clock);
    #1;
    reset         = 1'b1;
    exp_pc        = 32'h0;
    exp_req_pc    = 32'h0;
    parado_m      = 1'b0;
    req_bloq      = 1'b0;
    houve_desvio  = 1'b0;
    fim_req_ciclo = -1;
    ciclo         = 0;
    n_req         = 0;
    n_acc         = 0;
  endtask

  initial begin
    bus_b.inst_pronto   = 1'b1;
    bus_b.desvio_valido = 1'b0;
    bus_b.desvio_alvo   = '0;
    salt = 16'($urandom_range(0, 16'hFFFE));
    #2;

    // Streaming from reset with a constant program word.
    aplica_reset();
    passo(1, 0, 0);
    verifica("first_req", s_req, 1);
    verifica("first_ender", s_ender, 32'h0);
    verifica("lat_c0", s_valida, 0);
    passo(1, 0, 0);
    verifica("lat_c1", s_valida, 0);
    passo(1, 0, 0);
    verifica("lat_c2", s_valida, 1);
    for (int i = 0; i < 10; i++) begin
      passo(1, 0, 0);
      verifica("thr_valida", s_valida, 1);
      verifica("thr_req", s_req, 1);
    end

    // Reset mid-stream with a response on the bus; distinct words expose a stale push.
    modo_const = 1'b0;
    aplica_reset();
    passo(1, 0, 0);
    verifica("rel_req", s_req, 1);
    verifica("rel_ender", s_ender, 32'h0);

    // Downstream stall for 5 cycles after the first valid word.
    passo(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      passo(0, 0, 0);
      verifica("stall_pc", s_pc, 32'h0);
    end
    for (int i = 0; i < 6; i++) passo(1, 0, 0);

    // Redirect to 0x40 with 0x4 queued and 0x8 in flight.
    aplica_reset();
    for (int i = 0; i < 3; i++) passo(1, 0, 0);
    passo(0, 1, 32'h40);
    verifica("desv_head", s_pc, 32'h4);
    passo(1, 0, 0);
    verifica("desv_req", s_req, 1);
    verifica("desv_ender", s_ender, 32'h40);
    for (int i = 0; i < 4; i++) passo(1, 0, 0);

    // Unaligned target is word-aligned.
    passo(1, 1, 32'h43);
    passo(1, 0, 0);
    verifica("alin_ender", s_ender, 32'h40);
    for (int i = 0; i < 4; i++) passo(1, 0, 0);

    // End-of-program word at 0x10, then a redirect that must be ignored.
    fim_on = 1'b1;
    aplica_reset();
    for (int i = 0; i < 12; i++) passo(1, 0, 0);
    verifica("fim_parado", s_parado, 1);
    verifica("fim_valida", s_valida, 0);
    passo(1, 1, 32'h40);
    for (int i = 0; i < 3; i++) begin
      passo(1, 0, 0);
      verifica("fim_sem_req", s_req, 0);
    end

    // Redirect while the end marker is queued behind the head resumes fetching.
    aplica_reset();
    for (int i = 0; i < 5; i++) passo(1, 0, 0);
    passo(0, 0, 0);
    passo(0, 0, 0);
    passo(0, 1, 32'h40);
    for (int i = 0; i < 5; i++) passo(1, 0, 0);
    verifica("retoma_parado", s_parado, 0);

    // Random handshake and redirects.
    fim_on = 1'b0;
    aplica_reset();
    for (int i = 0; i < 400; i++)
      passo($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 6, $urandom);

    // Second instance: reset PC near the top of the address space wraps to 0.
    verifica("b_nreqs", reqs_b.size(), 3);
    if (reqs_b.size() >= 3) begin
      verifica("b_req0", reqs_b[0], 32'hFFFF_FFF8);
      verifica("b_req1", reqs_b[1], 32'hFFFF_FFFC);
      verifica("b_req2", reqs_b[2], 32'h0000_0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
